key_event_arbiter: RTL and testbench

Collects one-cycle press pulses from NKEY debouncers, holds each as a pending request, and issues them one at a time as key-ID events over a valid/ready handshake to the board-control logic (run/step/reset commands for the core). Arbitration is round-robin, so one key cannot starve the others. A press is reported lost when it arrives while that key's previous press is still pending. The block runs in the same 1 kHz domain as the debouncers.

---
 rtl/board_ctrl_pkg.sv | 16 +
 rtl/rr_pick.sv | 34 +++
 rtl/key_event_arbiter.sv | 86 ++++++++
 tb/tb_key_event_arbiter.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/board_ctrl_pkg.sv
// Shared board-control definitions: key indices, default key count, event FSM states.
package board_ctrl_pkg;

  localparam int unsigned NKEY_DEFAULT = 4;

  localparam int unsigned KEY_RUN  = 0;
  localparam int unsigned KEY_STEP = 1;
  localparam int unsigned KEY_RST  = 2;
  localparam int unsigned KEY_MODE = 3;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } evt_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
//   req_i          request vector
//   last_i         index granted most recently; search starts one above it
//   gnt_valid_c_o  at least one request is set
//   gnt_idx_c_o    first set request at or after (last_i+1) mod N, wrapping
module rr_pick
  import board_ctrl_pkg::*;
#(
  parameter int unsigned N  = NKEY_DEFAULT,
  parameter int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_i,
  output logic          gnt_valid_c_o,
  output logic [IW-1:0] gnt_idx_c_o
);

  // Walk offsets 1..N from last_i; the first hit wins, offset N revisits last_i itself.
  always_comb begin
    int unsigned j;
    j             = 0;
    gnt_valid_c_o = 1'b0;
    gnt_idx_c_o   = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      j = 32'(last_i) + k;
      if (j >= N) j = j - N;
      if (!gnt_valid_c_o && req_i[IW'(j)]) begin
        gnt_valid_c_o = 1'b1;
        gnt_idx_c_o   = IW'(j);
      end
    end
  end

endmodule

// File: rtl/key_event_arbiter.sv
// Key event arbiter: latches debouncer press pulses as pending requests and
// issues them one at a time, round-robin, as key-ID events over valid/ready.
//   clk1k_i      1 kHz clock
//   rst_i        asynchronous active-high reset
//   key_pulse_i  one-cycle press pulses, one bit per key
//   evt_ready_i  consumer accepts the current event
//   lost_clr_i   clears all lost flags
//   evt_valid_o  evt_id_o holds an unconsumed event
//   evt_id_o     index of the reported key
//   pending_o    pending-request register (debug view)
//   lost_o       sticky per-key dropped-press flags
module key_event_arbiter
  import board_ctrl_pkg::*;
#(
  parameter int unsigned NKEY = NKEY_DEFAULT,
  parameter int unsigned IDW  = $clog2(NKEY)
) (
  input  logic            clk1k_i,
  input  logic            rst_i,
  input  logic [NKEY-1:0] key_pulse_i,
  input  logic            evt_ready_i,
  input  logic            lost_clr_i,
  output logic            evt_valid_o,
  output logic [IDW-1:0]  evt_id_o,
  output logic [NKEY-1:0] pending_o,
  output logic [NKEY-1:0] lost_o
);

  evt_state_e      state_q;
  logic [IDW-1:0]  id_q;
  logic [IDW-1:0]  last_q;
  logic [NKEY-1:0] pend_q, pend_d;
  logic [NKEY-1:0] lost_q, lost_d;

  logic            gnt_valid_c;
  logic [IDW-1:0]  gnt_idx_c;
  logic            load_c;
  logic [NKEY-1:0] gnt_mask_c;

  rr_pick #(
    .N  (NKEY),
    .IW (IDW)
  ) u_rr_pick (
    .req_i         (pend_q),
    .last_i        (last_q),
    .gnt_valid_c_o (gnt_valid_c),
    .gnt_idx_c_o   (gnt_idx_c)
  );

  // Output slot is free when empty or being consumed this edge.
  always_comb begin
    load_c     = gnt_valid_c && ((state_q == EMPTY) || evt_ready_i);
    gnt_mask_c = '0;
    if (load_c) gnt_mask_c = NKEY'(1) << gnt_idx_c;
    // A pulse on the key being granted re-arms it rather than counting as lost.
    pend_d = (pend_q & ~gnt_mask_c) | key_pulse_i;
    lost_d = (lost_clr_i ? '0 : lost_q) | (key_pulse_i & pend_q & ~gnt_mask_c);
  end

  // Registers and output FSM.
  always_ff @(posedge clk1k_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= EMPTY;
      id_q    <= '0;
      last_q  <= IDW'(NKEY - 1);
      pend_q  <= '0;
      lost_q  <= '0;
    end else begin
      pend_q <= pend_d;
      lost_q <= lost_d;
      if (load_c) begin
        state_q <= FULL;
        id_q    <= gnt_idx_c;
        last_q  <= gnt_idx_c;
      end else if ((state_q == FULL) && evt_ready_i) begin
        state_q <= EMPTY;
      end
    end
  end

  assign evt_valid_o = (state_q == FULL);
  assign evt_id_o    = id_q;
  assign pending_o   = pend_q;
  assign lost_o      = lost_q;

endmodule

// File: tb/tb_key_event_arbiter.sv
// Bench for key_event_arbiter: directed scenarios with literal expectations,
// then randomized traffic, all compared cycle by cycle against a queue-free
// behavioural model of pending requests, lost flags and the output slot.
module tb_key_event_arbiter;
  localparam int unsigned NKEY = 4;
  localparam int unsigned IDW  = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NKEY-1:0] key_pulse = '0;
  logic            ready = 1'b0;
  logic            clr = 1'b0;
  logic            evt_valid;
  logic [IDW-1:0]  evt_id;
  logic [NKEY-1:0] pending;
  logic [NKEY-1:0] lost;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state
  bit       m_valid;
  int       m_id;
  int       m_last;
  bit       m_pend [NKEY];
  bit       m_lost [NKEY];

  key_event_arbiter #(.NKEY(NKEY), .IDW(IDW)) dut (
    .clk1k_i     (clk),
    .rst_i       (rst),
    .key_pulse_i (key_pulse),
    .evt_ready_i (ready),
    .lost_clr_i  (clr),
    .evt_valid_o (evt_valid),
    .evt_id_o    (evt_id),
    .pending_o   (pending),
    .lost_o      (lost)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [NKEY-1:0] pack(input bit v [NKEY]);
    logic [NKEY-1:0] r;
    for (int i = 0; i < NKEY; i++) r[i] = v[i];
    return r;
  endfunction

  task automatic model_reset();
    m_valid = 0;
    m_id    = 0;
    m_last  = NKEY - 1;
    for (int i = 0; i < NKEY; i++) begin
      m_pend[i] = 0;
      m_lost[i] = 0;
    end
  endtask

  // One clock edge of the specified behaviour.
  task automatic model_step(input logic [NKEY-1:0] p, input bit r, input bit c);
    int  grant;
    bit  any;
    bit  slot_free;
    grant = -1;
    any = 0;
    for (int i = 0; i < NKEY; i++) if (m_pend[i]) any = 1;
    slot_free = !m_valid || r;
    if (any && slot_free) begin
      for (int k = 1; k <= NKEY; k++) begin
        if (grant < 0 && m_pend[(m_last + k) % NKEY]) grant = (m_last + k) % NKEY;
      end
    end
    for (int i = 0; i < NKEY; i++) begin
      bit dropped;
      dropped = p[i] && m_pend[i] && (i != grant);
      if (c) m_lost[i] = 0;
      if (dropped) m_lost[i] = 1;
      if (i == grant) m_pend[i] = 0;
      if (p[i]) m_pend[i] = 1;
    end
    if (grant >= 0) begin
      m_valid = 1;
      m_id    = grant;
      m_last  = grant;
    end else if (m_valid && r) begin
      m_valid = 0;
    end
  endtask

  task automatic check_model();
    check("evt_valid", 32'(evt_valid), 32'(m_valid));
    check("evt_id",    32'(evt_id),    32'(m_id));
    check("pending",   32'(pending),   32'(pack(m_pend)));
    check("lost",      32'(lost),      32'(pack(m_lost)));
  endtask

  // Drive inputs, let one edge happen, then compare at the falling edge.
  task automatic cycle(input logic [NKEY-1:0] p, input bit r, input bit c);
    key_pulse = p;
    ready     = r;
    clr       = c;
    @(posedge clk);
    model_step(p, r, c);
    @(negedge clk);
    check_model();
  endtask

  // Assert reset between edges; outputs must clear without waiting for a clock.
  task automatic do_reset();
    key_pulse = '0;
    ready     = 1'b0;
    clr       = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("rst_valid",   32'(evt_valid), 32'd0);
    check("rst_id",      32'(evt_id),    32'd0);
    check("rst_pending", 32'(pending),   32'd0);
    check("rst_lost",    32'(lost),      32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    do_reset();

    // Single press, consumer always ready
    cycle(4'b0010, 1, 0);
    check("s1_pend", 32'(pending), 32'h2);
    check("s1_valid0", 32'(evt_valid), 32'd0);
    cycle(4'b0000, 1, 0);
    check("s1_valid1", 32'(evt_valid), 32'd1);
    check("s1_id", 32'(evt_id), 32'd1);
    check("s1_pend_clr", 32'(pending), 32'h0);
    cycle(4'b0000, 1, 0);
    check("s1_valid_drop", 32'(evt_valid), 32'd0);
    check("s1_lost", 32'(lost), 32'h0);

    // All keys at once: back-to-back 0,1,2,3
    do_reset();
    cycle(4'b1111, 1, 0);
    for (int k = 0; k < NKEY; k++) begin
      cycle(4'b0000, 1, 0);
      check("s2_valid", 32'(evt_valid), 32'd1);
      check("s2_order", 32'(evt_id), 32'(k));
    end
    cycle(4'b0000, 1, 0);
    check("s2_drop", 32'(evt_valid), 32'd0);

    // Wrap-around from LAST=1 with pending 0011 plus key 3
    do_reset();
    cycle(4'b0010, 1, 0);
    cycle(4'b0000, 1, 0);
    cycle(4'b1011, 0, 0);
    cycle(4'b0000, 1, 0);
    check("s3_g0", 32'(evt_id), 32'd3);
    cycle(4'b0000, 1, 0);
    check("s3_g1", 32'(evt_id), 32'd0);
    cycle(4'b0000, 1, 0);
    check("s3_g2", 32'(evt_id), 32'd1);

    // Same, with key 0 hammered: no second key-0 grant before 1 and 3
    do_reset();
    cycle(4'b0010, 1, 0);
    cycle(4'b0000, 1, 0);
    cycle(4'b1011, 0, 0);
    cycle(4'b0001, 1, 0);
    check("s3b_g0", 32'(evt_id), 32'd3);
    cycle(4'b0001, 1, 0);
    check("s3b_g1", 32'(evt_id), 32'd0);
    cycle(4'b0001, 1, 0);
    check("s3b_g2", 32'(evt_id), 32'd1);
    cycle(4'b0000, 1, 0);
    check("s3b_g3", 32'(evt_id), 32'd0);

    // Stalled consumer, repeated presses of key 2
    do_reset();
    cycle(4'b0100, 0, 0);
    cycle(4'b0000, 0, 0);
    cycle(4'b0000, 0, 0);
    cycle(4'b0100, 0, 0);
    check("s4_pend2", 32'(pending), 32'h4);
    check("s4_nolost", 32'(lost), 32'h0);
    check("s4_id_stable", 32'(evt_id), 32'd2);
    cycle(4'b0000, 0, 0);
    cycle(4'b0100, 0, 0);
    check("s4_lost2", 32'(lost), 32'h4);
    check("s4_id_stable2", 32'(evt_id), 32'd2);
    check("s4_valid_held", 32'(evt_valid), 32'd1);

    // LOST_CLR racing a new loss of key 1, then LOST_CLR alone
    cycle(4'b0010, 0, 0);
    cycle(4'b0010, 0, 1);
    check("s5_set_wins", 32'(lost), 32'h2);
    cycle(4'b0000, 0, 1);
    check("s5_clr", 32'(lost), 32'h0);

    // Grant of key 1 coinciding with a new press of key 1
    do_reset();
    cycle(4'b0010, 1, 0);
    cycle(4'b0010, 1, 0);
    check("s6_pend_kept", 32'(pending), 32'h2);
    check("s6_id_a", 32'(evt_id), 32'd1);
    cycle(4'b0000, 1, 0);
    check("s6_second_valid", 32'(evt_valid), 32'd1);
    check("s6_id_b", 32'(evt_id), 32'd1);
    check("s6_lost", 32'(lost), 32'h0);

    // Reset in the middle of a handshake with requests outstanding
    do_reset();
    cycle(4'b0101, 0, 0);
    cycle(4'b0000, 0, 0);
    cycle(4'b0001, 0, 0);
    check("s7_pre_pend", 32'(pending), 32'h5);
    check("s7_pre_valid", 32'(evt_valid), 32'd1);
    do_reset();
    for (int k = 0; k < 3; k++) cycle(4'b0000, 1, 0);
    check("s7_quiet", 32'(evt_valid), 32'd0);
    cycle(4'b1000, 1, 0);
    cycle(4'b0000, 1, 0);
    check("s7_new_evt", 32'(evt_id), 32'd3);

    // Randomized traffic in phases of varying consumer readiness
    for (int ph = 0; ph < 8; ph++) begin
      int rdy_pct;
      rdy_pct = (ph % 4) * 30 + 5;
      for (int n = 0; n < 250; n++) begin
        logic [NKEY-1:0] p;
        bit r, c;
        p = NKEY'($urandom & $urandom);
        r = ($urandom_range(0, 99) < rdy_pct);
        c = ($urandom_range(0, 19) == 0);
        cycle(p, r, c);
      end
      if (ph == 5) do_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
